// File: rtl/dip_input_conditioner_pkg.sv
// Shared constants and types for the scanned DIP/push-switch input path.
// The sample word packs the switches above the DIP bits, as the parallelizer presents them.
package dip_input_conditioner_pkg;

  localparam int DIP_W          = 16;
  localparam int SW_W           = 5;
  localparam int SCAN_FRAME_LEN = 24;
  localparam int STAB_W         = 4;

  typedef struct packed {
    logic [SW_W-1:0]  sw;
    logic [DIP_W-1:0] dip;
  } sample_t;

  // Saturating increment used by the stability counter.
  function automatic logic [STAB_W-1:0] sat_inc(input logic [STAB_W-1:0] cnt,
                                                input logic [STAB_W-1:0] lim);
    return (cnt >= lim) ? lim : cnt + STAB_W'(1);
  endfunction

endpackage

// File: rtl/dip_input_conditioner_if.sv
// Raw parallel words in, debounced levels and sticky event flags out.
// The master side is the parallelizer/CPU glue; the slave side is the conditioner.
interface dip_input_conditioner_if;
  import dip_input_conditioner_pkg::*;

  logic [DIP_W-1:0] i_DIP16;
  logic [SW_W-1:0]  i_Switch5;
  logic             i_EventAck;
  logic [DIP_W-1:0] o_DIP16;
  logic [SW_W-1:0]  o_Switch5;
  logic [SW_W-1:0]  o_BtnEvents;
  logic             o_DIPChanged;
  logic             o_EventValid;

  modport master (
    output i_DIP16, i_Switch5, i_EventAck,
    input  o_DIP16, o_Switch5, o_BtnEvents, o_DIPChanged, o_EventValid
  );

  modport slave (
    input  i_DIP16, i_Switch5, i_EventAck,
    output o_DIP16, o_Switch5, o_BtnEvents, o_DIPChanged, o_EventValid
  );
endinterface

// File: rtl/dip_sample_prescaler.sv
// Free-running 0..SAMPLE_DIV-1 counter; tick marks the last count of each scan frame.
module dip_sample_prescaler #(
  parameter int SAMPLE_DIV = 24
) (
  input  logic i_CLK,
  input  logic i_RESET,
  output logic tick
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: registered state is always updated with non-blocking assignments so
  // every always_ff sees the pre-edge value of every other register.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) cnt <= '0;
    else         cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/dip_input_conditioner.sv
// Debounces the scanned DIP/switch word: a value is committed after STABLE_COUNT identical
// samples, switch rises and DIP changes are latched into sticky flags cleared by i_EventAck.
module dip_input_conditioner
  import dip_input_conditioner_pkg::*;
#(
  parameter int SAMPLE_DIV   = SCAN_FRAME_LEN,
  parameter int STABLE_COUNT = 4
) (
  input  logic                   i_CLK,
  input  logic                   i_RESET,
  dip_input_conditioner_if.slave bus
);

  localparam logic [STAB_W-1:0] STABLE_LIM = STAB_W'(STABLE_COUNT);

  logic              tick;
  sample_t           s;
  sample_t           cand;
  logic [STAB_W-1:0] stab_cnt;
  logic [STAB_W-1:0] stab_next;
  logic              commit;
  logic [SW_W-1:0]   rise;
  logic              dip_diff;
  logic [DIP_W-1:0]  dip_q;
  logic [SW_W-1:0]   sw_q;
  logic [SW_W-1:0]   btn_q;
  logic              dipchg_q;

  dip_sample_prescaler #(.SAMPLE_DIV(SAMPLE_DIV)) u_prescaler (
    .i_CLK   (i_CLK),
    .i_RESET (i_RESET),
    .tick    (tick)
  );

  assign s = {bus.i_Switch5, bus.i_DIP16};

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    stab_next = stab_cnt;
    if (tick) stab_next = (s != cand) ? STAB_W'(1) : sat_inc(stab_cnt, STABLE_LIM);
  end

  // Event terms compare against the levels published before this commit.
  assign commit   = tick && (stab_next == STABLE_LIM);
  assign rise     = s.sw & ~sw_q;
  assign dip_diff = (s.dip != dip_q);

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      cand     <= '0;
      stab_cnt <= '0;
      dip_q    <= '0;
      sw_q     <= '0;
      btn_q    <= '0;
      dipchg_q <= 1'b0;
    end else begin
      if (tick) begin
        cand     <= s;
        stab_cnt <= stab_next;
      end
      if (commit) begin
        dip_q <= s.dip;
        sw_q  <= s.sw;
      end
      // A new event wins over an acknowledge landing on the same edge.
      btn_q    <= (btn_q & ~{SW_W{bus.i_EventAck}}) | (commit ? rise : '0);
      dipchg_q <= (dipchg_q & ~bus.i_EventAck) | (commit & dip_diff);
    end
  end

  assign bus.o_DIP16      = dip_q;
  assign bus.o_Switch5    = sw_q;
  assign bus.o_BtnEvents  = btn_q;
  assign bus.o_DIPChanged = dipchg_q;
  assign bus.o_EventValid = (|btn_q) | dipchg_q;

endmodule

// File: doc/dip_input_conditioner.md
# dip_input_conditioner

Downstream consumer of the DIP parallelizer's parallel outputs (16 DIP bits, 5 push-switch bits). It samples the raw parallel word once per scan frame and accepts a new value only after it has been identical for `STABLE_COUNT` consecutive samples. It publishes the debounced levels and latches switch-press and DIP-change events into sticky flags. The CPU-side I/O logic reads these flags and clears them with a single-cycle acknowledge.

## Interface
- `SAMPLE_DIV`, default 24: clocks between samples. Equals the parallelizer frame length (24 positions).
- `STABLE_COUNT`, default 4: consecutive identical samples required before a commit. Legal range is 1..15.
- `i_CLK` in 1: clock.
- `i_RESET` in 1: reset, synchronous, active-high.
- `i_DIP16` in 16: raw DIP word from the parallelizer.
- `i_Switch5` in 5: raw push-switch word from the parallelizer.
- `i_EventAck` in 1: one-cycle pulse that clears the reported event flags.
- `o_DIP16` out 16: debounced DIP level.
- `o_Switch5` out 5: debounced switch level.
- `o_BtnEvents` out 5: sticky flags, one per switch. A bit sets on a debounced 0→1 transition of that switch.
- `o_DIPChanged` out 1: sticky flag. Sets when a commit changes `o_DIP16`.
- `o_EventValid` out 1: `|o_BtnEvents | o_DIPChanged`. Combinational from registers only.

## Operation
- **Prescaler**
  - Counts 0..SAMPLE_DIV-1 and wraps to 0.
  - `tick` is asserted while the count equals SAMPLE_DIV-1.
- **Sample word**
  - S = {i_Switch5, i_DIP16}, 21 bits.
  - Compared against the internal `cand` register (21 bits).
- **Stability counter**
  - `stab_cnt` is 4 bits.
  - On a tick with S != cand: cand←S and stab_cnt←1.
  - On a tick with S == cand: stab_cnt←min(stab_cnt+1, STABLE_COUNT).
  - On a non-tick cycle: no change.
- **Commit**
  - Occurs at any tick edge where the post-update stab_cnt == STABLE_COUNT.
  - On commit: o_Switch5←S[20:16] and o_DIP16←S[15:0].
  - Repeated commits with an unchanged value are harmless: no level change, no events.
- **Event generation on commit**
  - rise = S[20:16] & ~o_Switch5, using the old register value.
  - A held switch yields exactly one event.
  - A release yields no event.
  - DIP event condition: S[15:0] != o_DIP16 (old value).
- **Flag update each cycle**
  - o_BtnEvents ← (o_BtnEvents & ~{5{i_EventAck}}) | (commit ? rise : 0).
  - o_DIPChanged ← (o_DIPChanged & ~i_EventAck) | (commit & dip_diff).
  - When an ack and a commit that sets a flag coincide, the new event survives.
- **Ack with o_EventValid low**: no effect.
- **Reset values**: all zero. This covers prescaler, cand, stab_cnt, o_DIP16, o_Switch5, o_BtnEvents, o_DIPChanged and o_EventValid.
- **Reset mid-operation**
  - Reset aborts any partial stability count.
  - Reset discards pending events.
  - Sampling restarts from prescaler 0.

## Timing
- First tick is the 24th rising edge after i_RESET deasserts: prescaler 0 on the first edge, tick at count 23.
- Output latency after a stable input change is between (STABLE_COUNT-1)·SAMPLE_DIV+1 and STABLE_COUNT·SAMPLE_DIV clocks, depending on phase. Outputs and flags are registered at the commit edge.
- o_EventValid follows the flag registers with zero added latency.
- A flag clears on the edge that samples i_EventAck=1. o_EventValid falls in the same cycle the flags clear.
- An input glitch shorter than one sample period is invisible unless it coincides with a tick. A glitch that is sampled resets stab_cnt to 1.
- No handshake back to the parallelizer. Inputs are treated as synchronous to i_CLK.

## Structure
- **Shared package constants**
  - DIP_W=16.
  - SW_W=5.
  - SCAN_FRAME_LEN=24, the parallelizer frame length and the default for SAMPLE_DIV.
- **Sub-module `dip_sample_prescaler`**
  - Contents: the SAMPLE_DIV counter.
  - Inputs: i_CLK, i_RESET.
  - Output: tick.
  - Reused by other scanned-I/O blocks.
- **Top**: the remaining logic is the stability counter, cand, the output registers and the flag logic.

## Test plan
All scenarios use defaults (SAMPLE_DIV=24, STABLE_COUNT=4) unless stated.
1. **Clean press.** Release reset with i_DIP16=16'hA5A5 and i_Switch5=5'b00100 held.
   - Ticks fall at cycles 23, 47, 71 and 95.
   - Commit at cycle 95: o_DIP16=A5A5, o_Switch5=00100, o_BtnEvents=00100, o_DIPChanged=1, o_EventValid=1.
2. **Bounce rejection.** Toggle i_Switch5[0] every 24 clocks (once per sample) for 12 samples.
   - o_Switch5 stays 0 and o_EventValid stays 0.
   - Then hold the input at 1 for 4 samples: a single event, o_BtnEvents=00001.
3. **Hold and release.** After scenario 1, ack, then hold the switch for 20 samples and release it for 4 samples.
   - No new event occurs.
   - o_Switch5 returns to 0.
   - o_EventValid stays 0 throughout.
4. **Ack/commit collision.** With o_BtnEvents=00100 pending, pulse i_EventAck in the same cycle a commit produces rise=00010.
   - Next cycle: o_BtnEvents=00010 and o_EventValid=1.
5. **Reset mid-count.** Apply a new value for 3 samples, then assert i_RESET for 1 cycle.
   - All outputs are 0.
   - The next commit occurs exactly 4 ticks later, first tick at cycle 23 after release.
6. **STABLE_COUNT=1.** Change i_DIP16 from 0000 to 00FF.
   - Commit at the first tick after the change.
   - o_DIPChanged=1.
   - An ack with o_EventValid=0 has no effect.
